// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: command FIFO feeding an APB initiator (SETUP/ACCESS, no PREADY)
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready            host command handshake (ready = FIFO not full)
//   cmd_write/cmd_addr/cmd_wdata   command payload (wdata ignored for reads)
//   rsp_valid/rsp_rdata            one-cycle read-data strobe, data held until next read
//   fifo_level, busy               FIFO occupancy; FIFO non-empty or transfer in flight
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA/PRDATA  APB master port
module apb_master_ctrl #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AMBA_WORD-1:0]       cmd_wdata,
    output logic                       rsp_valid,
    output logic [AMBA_WORD-1:0]       rsp_rdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                       busy,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_WORD-1:0]       PWDATA,
    input  logic [AMBA_WORD-1:0]       PRDATA
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = 1 + AMBA_ADDR_WIDTH + AMBA_WORD;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] head;
    logic          push, pop;

    assign cmd_ready = fifo_level != LW'(FIFO_DEPTH);
    assign busy      = (fifo_level != '0) || (state != IDLE);
    assign push      = cmd_valid && cmd_ready;
    // a new transfer may start from IDLE or straight out of ACCESS (back-to-back)
    assign pop       = (state != SETUP) && (fifo_level != '0);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PW'(push);
            rd_ptr     <= rd_ptr + PW'(pop);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            rsp_valid  <= state == ACCESS && !PWRITE;
            if (state == ACCESS && !PWRITE)
                rsp_rdata <= PRDATA;
            if (pop) begin
                state   <= SETUP;
                PSEL    <= 1'b1;
                PENABLE <= 1'b0;
                PWRITE  <= head[EW-1];
                PADDR   <= head[EW-2 -: AMBA_ADDR_WIDTH];
                // reads leave PWDATA at the last written value
                if (head[EW-1])
                    PWDATA <= head[AMBA_WORD-1:0];
            end else if (state == SETUP) begin
                state   <= ACCESS;
                PENABLE <= 1'b1;
            end else begin
                state   <= IDLE;
                PSEL    <= 1'b0;
                PENABLE <= 1'b0;
            end
        end
    end
endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- APB initiator that drives the ECC register bank's APB slave port from a simple command/response interface.
- Host-side commands (write or read, address, data) are buffered in a small FIFO and issued as APB SETUP/ACCESS transfers.
- Read data returns on a one-cycle response strobe.
- Used by the system bench and by on-chip sequencers to program CTRL/DATA_IN/CODEWORD_WIDTH/NOISE and read back results.

Parameters:
AMBA_WORD, 32, APB data width (PWDATA/PRDATA, cmd_wdata, rsp_rdata)
AMBA_ADDR_WIDTH, 20, APB address width
FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; high iff FIFO not full
cmd_write  in  1  1 = APB write, 0 = APB read
cmd_addr  in  AMBA_ADDR_WIDTH  target address
cmd_wdata  in  AMBA_WORD  write data; ignored for reads
rsp_valid  out  1  one-cycle pulse, read data available
rsp_rdata  out  AMBA_WORD  captured PRDATA; held until next read completes
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
busy  out  1  FIFO non-empty or FSM not IDLE
PADDR  out  AMBA_ADDR_WIDTH  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  AMBA_WORD  APB write data
PRDATA  in  AMBA_WORD  APB read data from slave

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All state and outputs are registered.
- Reset values:
  - PSEL, PENABLE, PWRITE, rsp_valid, busy = 0.
  - PADDR, PWDATA, rsp_rdata = 0.
  - FIFO empty, fifo_level = 0, cmd_ready = 1, FSM = IDLE.
- Push:
  - A command is accepted on a clock edge where cmd_valid && cmd_ready.
  - When full, cmd_ready = 0 and no push occurs, even if a pop happens in the same cycle (no push-through-full).
- FSM has three states.
  - IDLE:
    - PSEL = 0, PENABLE = 0.
    - If FIFO non-empty: pop head, load PADDR/PWRITE/PWDATA, go to SETUP.
  - SETUP:
    - PSEL = 1, PENABLE = 0.
    - Always go to ACCESS next cycle.
  - ACCESS:
    - PSEL = 1, PENABLE = 1.
    - The slave has no PREADY, so the transfer completes at the end of this single cycle.
    - If the transfer is a read, capture PRDATA into rsp_rdata on this edge and pulse rsp_valid for the following cycle.
    - If FIFO non-empty: pop, reload, go directly to SETUP (back-to-back, PSEL stays high). Otherwise go to IDLE.
- Stability:
  - PADDR/PWRITE/PWDATA are constant from SETUP through ACCESS.
  - In IDLE they hold the last transfer's values. PWDATA holds its prior value on reads.
- Latency and throughput:
  - A push at edge N with FSM IDLE and FIFO empty gives: SETUP visible after edge N+1, ACCESS after edge N+2, rsp_valid after edge N+3.
  - Sustained throughput is 1 transfer per 2 cycles.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
  - fifo_level = pushes - pops. A simultaneous push and pop leaves the level unchanged.
  - The FIFO pops only on transitions into SETUP.
- Ordering: transfers are issued strictly in push order. rsp_valid is never asserted for writes.
- Reset mid-operation:
  - Any state returns to IDLE next cycle, with APB outputs at their reset values.
  - FIFO is flushed. The aborted transfer is neither completed nor replayed, and no rsp_valid is generated for it.

Test Plan:
- Single write: push write addr 0x00004, data 0xA5A5A5A5 into idle block.
  - Edge N+1: PSEL=1, PENABLE=0, PWRITE=1, PADDR=0x00004, PWDATA=0xA5A5A5A5.
  - Edge N+2: PENABLE=1.
  - Edge N+3: PSEL=0, no rsp_valid.
- Single read: push read addr 0x00010 with slave driving PRDATA=0x0000_00C3.
  - rsp_valid=1 for exactly one cycle at N+3, rsp_rdata=0xC3; rsp_rdata holds after the pulse.
- Back-to-back: push W(0x0,0x1), W(0x8,0x2), R(0xC) on consecutive cycles.
  - PSEL stays high for 6 cycles.
  - PENABLE pattern is 0,1,0,1,0,1.
  - Addresses appear in order.
  - One rsp_valid, after the read's ACCESS.
- Full FIFO: hold cmd_valid with PSEL stalled behind a transfer until fifo_level = 4.
  - cmd_ready=0, and a push attempt that cycle is dropped even though a pop occurs.
  - cmd_ready returns to 1 the cycle after the level drops to 3.
- Reset mid-ACCESS: assert rst during the ACCESS of a read with 2 commands queued.
  - Next cycle: PSEL=PENABLE=0, fifo_level=0, busy=0, no rsp_valid.
  - A new command after reset is issued normally.
- Wrap-around: push and complete 10 single writes with distinct addresses.
  - Every address appears on PADDR exactly once, in order, across pointer wrap.
